case_9_acc_8s_16s: RTL and testbench
====================================

# case_9_acc_8s_16s

Streaming signed accumulator that sits directly downstream of the `case_9` 5s×3s→8-bit signed multiplier. It consumes the multiplier's 8-bit signed products over a valid/ready handshake and sums each fixed-length frame of `LEN` products into a wider accumulator. It then presents the frame sum on a registered valid/ready output. Overflow handling (saturate vs. wrap) is selected at compile time.

## Interface
- `PROD_WIDTH`, 8: width of the signed product input.
- `ACC_WIDTH`, 16: width of the signed accumulator and of the result. Must be ≥ `PROD_WIDTH`.
- `LEN`, 4: products per frame. Range 1..255.
- `CNT_WIDTH`, 8: width of the internal product counter. Must satisfy 2^`CNT_WIDTH` > `LEN`.

- `ap_clk`  in  1  clock; all logic is rising-edge.
- `ap_rst_n`  in  1  reset; asynchronous assert, active-low.
- `prod_tdata`  in  `PROD_WIDTH`  signed product from the multiplier.
- `prod_tvalid`  in  1  product valid.
- `prod_tready`  out  1  accumulator can accept a product.
- `acc_tdata`  out  `ACC_WIDTH`  signed frame sum; registered.
- `acc_tvalid`  out  1  frame sum valid.
- `acc_tready`  in  1  downstream accepts the sum.
- `acc_ovf`  out  1  sticky overflow flag for the current frame; registered.

## Operation
- State machine has two states:
  - `ACCUM`: collecting products.
  - `OUT`: holding the result.
- Reset state is `ACCUM`. On reset: accumulator = 0, count = 0, `acc_tdata` = 0, `acc_tvalid` = 0, `acc_ovf` = 0.
- In `ACCUM`:
  - `prod_tready` = 1.
  - A product is accepted on any cycle where `prod_tvalid` & `prod_tready`.
  - An accepted product is sign-extended to `ACC_WIDTH` and added to the accumulator. The addition uses `ACC_WIDTH`+1 bits internally to detect overflow. Count increments.
- When the `LEN`-th product of a frame is accepted:
  - The final sum (including that product) is loaded into `acc_tdata`.
  - `acc_tvalid` goes to 1 and the state moves to `OUT` on the same edge.
  - The accumulator and count are cleared.
- In `OUT`:
  - `prod_tready` = 0.
  - `acc_tdata`, `acc_tvalid` and `acc_ovf` stay stable until `acc_tvalid` & `acc_tready`.
  - On that handshake edge: `acc_tvalid` → 0, `acc_ovf` → 0, state → `ACCUM`.
  - `acc_tdata` keeps its last value after the handshake and is don't-care while `acc_tvalid` = 0.
- Overflow is checked on every addition. It occurs when the true sum falls outside [-2^(`ACC_WIDTH`-1), 2^(`ACC_WIDTH`-1)-1]. Handling is set by `CASE_9_ACC_SAT_EN` (see Configuration).
- `prod_tready` is a pure function of state. It has no combinational path from `acc_tready` or `prod_tvalid`.
- `prod_tvalid` while `prod_tready` = 0 is ignored. The upstream stage holds `prod_tdata`.
- An `ap_rst_n` assertion mid-frame or in `OUT` immediately discards the partial sum and any pending result, and returns all registers to their reset values.

## Timing
- Product-to-result latency: `acc_tvalid` rises on the edge that accepts the `LEN`-th product.
- Peak throughput: one product per cycle within a frame.
- Per-frame cost: `LEN` accept cycles plus at least 1 `OUT` cycle. The minimum frame period is `LEN`+1 cycles.
- If `acc_tready` is already 1 on the first `OUT` cycle, the state returns to `ACCUM` on the next edge, and product acceptance resumes that cycle.
- With `LEN` = 1, every accepted product produces a result. Accept and output cycles alternate.

## Configuration
- `CASE_9_ACC_SAT_EN` defined:
  - Each addition that overflows clamps the accumulator to +2^(`ACC_WIDTH`-1)-1 or -2^(`ACC_WIDTH`-1), following the sign of the true sum.
  - `acc_ovf` is set sticky for the frame and presented with the result.
  - Later additions in the same frame continue from the clamped value.
- `CASE_9_ACC_SAT_EN` undefined:
  - The accumulator wraps modulo 2^`ACC_WIDTH` (two's complement).
  - `acc_ovf` is tied to 0 and the overflow detection logic is removed.

## Test plan
- Reset then basic frame (`LEN`=4, `ACC_WIDTH`=16): products 10, -3, 127, -128 with back-to-back valid.
  - Expect `acc_tdata` = 16'h0006, `acc_tvalid` = 1 on the 4th accept edge, `acc_ovf` = 0.
- Output backpressure: hold `acc_tready` = 0 for 5 cycles after the result.
  - `acc_tdata` and `acc_tvalid` stay stable and `prod_tready` = 0 throughout.
  - After the handshake, the next frame 1, 1, 1, 1 yields 16'h0004 with no carry-over from the previous frame.
- Input bubbles: `prod_tvalid` toggles 1,0,0,1,0,1,1 carrying 5, -, -, 5, -, 5, 5.
  - Only the valid beats count; result = 16'h0014.
- Overflow (`ACC_WIDTH`=10, `LEN`=8): eight products of 127 (true sum 1016).
  - With `CASE_9_ACC_SAT_EN`: result 10'h1FF (511), `acc_ovf` = 1.
  - Without: result 10'h3F8 (-8), `acc_ovf` = 0.
- Negative saturation (`ACC_WIDTH`=10, `LEN`=8, macro defined): eight products of -128 (true sum -1024).
  - Result 10'h200 (-512), `acc_ovf` = 1.
  - The following frame 0×8 returns 10'h000 with `acc_ovf` = 0.
- Reset mid-frame: accept 2 products of 50, pulse `ap_rst_n` low, then send 4 products of 1.
  - All outputs read 0 during reset, and the frame result is 16'h0004.

Source files
------------

// File: rtl/case_9_acc_8s_16s.sv
// case_9_acc_8s_16s
// Streaming signed accumulator placed after the case_9 multiplier. Sums each
// frame of LEN signed products into an ACC_WIDTH accumulator and presents the
// frame sum on a registered valid/ready output.
//
// Compile-time option: CASE_9_ACC_SAT_EN
//   defined   - saturating adds; acc_ovf is a sticky per-frame overflow flag
//   undefined - two's-complement wrap; acc_ovf tied to 0
//
// Ports
//   ap_clk        in   clock, rising edge
//   ap_rst_n      in   asynchronous active-low reset
//   prod_tdata    in   signed product (PROD_WIDTH)
//   prod_tvalid   in   product valid
//   prod_tready   out  product accepted this cycle when valid (state only)
//   acc_tdata     out  signed frame sum (ACC_WIDTH), registered
//   acc_tvalid    out  frame sum valid
//   acc_tready    in   downstream accepts the sum
//   acc_ovf       out  sticky overflow flag for the current frame, registered
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_ACCUM | collecting products, prod_tready = 1
// ST_OUT   | holding frame sum until acc_tvalid & acc_tready

module case_9_acc_8s_16s #(
    parameter int PROD_WIDTH = 8,
    parameter int ACC_WIDTH  = 16,
    parameter int LEN        = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic [PROD_WIDTH-1:0] prod_tdata,
    input  logic                  prod_tvalid,
    output logic                  prod_tready,
    output logic [ACC_WIDTH-1:0]  acc_tdata,
    output logic                  acc_tvalid,
    input  logic                  acc_tready,
    output logic                  acc_ovf
);

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_OUT   = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(LEN - 1);

    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q,   acc_d;
    logic [CNT_WIDTH-1:0]   cnt_q,   cnt_d;
    logic [ACC_WIDTH-1:0]   res_q,   res_d;
    logic                   vld_q,   vld_d;
    logic [ACC_WIDTH-1:0]   acc_nxt;

`ifdef CASE_9_ACC_SAT_EN
    localparam int AW1 = ACC_WIDTH + 1;
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH:0] sum_w;
    logic                      ovf_now;
    logic                      ovf_q, ovf_d;

    // One guard bit: the true sum overflowed when the two top bits disagree,
    // and the guard bit then carries the sign of the true sum.
    always_comb begin
        sum_w   = AW1'($signed(acc_q)) + AW1'($signed(prod_tdata));
        ovf_now = sum_w[ACC_WIDTH] ^ sum_w[ACC_WIDTH-1];
        if (ovf_now) begin
            acc_nxt = sum_w[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end else begin
            acc_nxt = sum_w[ACC_WIDTH-1:0];
        end
    end
`else
    always_comb begin
        acc_nxt = acc_q + ACC_WIDTH'($signed(prod_tdata));
    end
`endif

    assign prod_tready = (state_q == ST_ACCUM);
    assign acc_tdata   = res_q;
    assign acc_tvalid  = vld_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        vld_d   = vld_q;
`ifdef CASE_9_ACC_SAT_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            ST_ACCUM: begin
                if (prod_tvalid) begin
                    acc_d = acc_nxt;
`ifdef CASE_9_ACC_SAT_EN
                    ovf_d = ovf_q | ovf_now;
`endif
                    if (cnt_q == CNT_LAST) begin
                        res_d   = acc_nxt;
                        vld_d   = 1'b1;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = ST_OUT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_OUT: begin
                // res_q deliberately keeps its value after the handshake
                if (acc_tready) begin
                    vld_d   = 1'b0;
`ifdef CASE_9_ACC_SAT_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = ST_ACCUM;
                end
            end
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= ST_ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            vld_q   <= vld_d;
        end
    end

`ifdef CASE_9_ACC_SAT_EN
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign acc_ovf = ovf_q;
`else
    assign acc_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_case_9_acc_8s_16s.sv
// Scoreboard bench for case_9_acc_8s_16s. Two instances: the default
// 16-bit / LEN=4 build and a 10-bit / LEN=8 build for overflow cases.
// Expected overflow behaviour follows CASE_9_ACC_SAT_EN.

module tb_case_9_acc_8s_16s;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;

    logic [7:0]  a_tdata, b_tdata;
    logic        a_tvalid, b_tvalid;
    logic        a_ptr, b_ptr;
    logic [15:0] a_acc;
    logic [9:0]  b_acc;
    logic        a_vld, b_vld;
    logic        a_rdy, b_rdy;
    logic        a_ovf, b_ovf;

    int n_cmp = 0;
    int n_err = 0;

    logic [16:0] q_a[$];   // {ovf, data}
    logic [10:0] q_b[$];

    always #5 ap_clk = ~ap_clk;

    case_9_acc_8s_16s #(
        .PROD_WIDTH(8), .ACC_WIDTH(16), .LEN(4), .CNT_WIDTH(8)
    ) u_dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .prod_tdata(a_tdata), .prod_tvalid(a_tvalid), .prod_tready(a_ptr),
        .acc_tdata(a_acc), .acc_tvalid(a_vld), .acc_tready(a_rdy),
        .acc_ovf(a_ovf)
    );

    case_9_acc_8s_16s #(
        .PROD_WIDTH(8), .ACC_WIDTH(10), .LEN(8), .CNT_WIDTH(8)
    ) u_dut10 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .prod_tdata(b_tdata), .prod_tvalid(b_tvalid), .prod_tready(b_ptr),
        .acc_tdata(b_acc), .acc_tvalid(b_vld), .acc_tready(b_rdy),
        .acc_ovf(b_ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Leaves the caller 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge ap_clk);
        #1;
    endtask

    // Present one product and hold it until the DUT accepts it.
    task automatic send(input int which, input logic [7:0] d);
        bit ok;
        ok = 1'b0;
        if (which == 0) begin a_tdata = d; a_tvalid = 1'b1; end
        else            begin b_tdata = d; b_tvalid = 1'b1; end
        for (int i = 0; i < 50 && !ok; i++) begin
            ok = (which == 0) ? a_ptr : b_ptr;
            idle(1);
        end
        if (which == 0) a_tvalid = 1'b0;
        else            b_tvalid = 1'b0;
        chk("send_accept", {31'd0, ok}, 32'd1);
    endtask

    task automatic drain(input int which);
        int i;
        i = 0;
        while (((which == 0) ? q_a.size() : q_b.size()) != 0 && i < 100) begin
            idle(1);
            i++;
        end
        chk("drain", (which == 0) ? q_a.size() : q_b.size(), 0);
    endtask

    always @(negedge ap_clk) begin
        if (ap_rst_n && a_vld && a_rdy) begin
            if (q_a.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL a_unexpected: got %0h, expected no result", a_acc);
            end else begin
                logic [16:0] e;
                e = q_a.pop_front();
                chk("a_data", {16'd0, a_acc}, {16'd0, e[15:0]});
                chk("a_ovf",  {31'd0, a_ovf}, {31'd0, e[16]});
            end
        end
    end

    always @(negedge ap_clk) begin
        if (ap_rst_n && b_vld && b_rdy) begin
            if (q_b.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL b_unexpected: got %0h, expected no result", b_acc);
            end else begin
                logic [10:0] e;
                e = q_b.pop_front();
                chk("b_data", {22'd0, b_acc}, {22'd0, e[9:0]});
                chk("b_ovf",  {31'd0, b_ovf}, {31'd0, e[10]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        ap_rst_n = 1'b0;
        a_tdata = '0; b_tdata = '0;
        a_tvalid = 1'b0; b_tvalid = 1'b0;
        a_rdy = 1'b0; b_rdy = 1'b1;
        idle(3);
        chk("rst_vld",  {31'd0, a_vld}, 32'd0);
        chk("rst_data", {16'd0, a_acc}, 32'd0);
        chk("rst_ovf",  {31'd0, a_ovf}, 32'd0);
        chk("rst_ptr",  {31'd0, a_ptr}, 32'd1);
        ap_rst_n = 1'b1;
        idle(2);

        // basic frame 10, -3, 127, -128 -> 6, with output backpressure
        q_a.push_back({1'b0, 16'h0006});
        send(0, 8'd10);
        send(0, 8'hFD);
        send(0, 8'h7F);
        send(0, 8'h80);
        chk("lat_vld",  {31'd0, a_vld}, 32'd1);
        chk("lat_data", {16'd0, a_acc}, 32'h0006);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            chk("bp_vld",  {31'd0, a_vld}, 32'd1);
            chk("bp_data", {16'd0, a_acc}, 32'h0006);
            chk("bp_ptr",  {31'd0, a_ptr}, 32'd0);
        end
        a_rdy = 1'b1;
        drain(0);

        // next frame with no carry-over
        q_a.push_back({1'b0, 16'h0004});
        for (int i = 0; i < 4; i++) send(0, 8'd1);
        drain(0);

        // input bubbles: valid 1,0,0,1,0,1,1 carrying 5,-,-,5,-,5,5
        q_a.push_back({1'b0, 16'h0014});
        begin
            logic [6:0] pat;
            pat = 7'b1101001;  // bit i = beat i
            for (int i = 0; i < 7; i++) begin
                if (pat[i]) send(0, 8'd5);
                else begin
                    a_tdata = 8'd99; a_tvalid = 1'b0;
                    idle(1);
                end
            end
        end
        drain(0);

        // reset mid-frame
        send(0, 8'd50);
        send(0, 8'd50);
        ap_rst_n = 1'b0;
        #2;
        chk("mrst_vld",  {31'd0, a_vld}, 32'd0);
        chk("mrst_data", {16'd0, a_acc}, 32'd0);
        chk("mrst_ovf",  {31'd0, a_ovf}, 32'd0);
        idle(2);
        ap_rst_n = 1'b1;
        idle(1);
        q_a.push_back({1'b0, 16'h0004});
        for (int i = 0; i < 4; i++) send(0, 8'd1);
        drain(0);

        // 10-bit accumulator: 8 x 127, 8 x -128, 8 x 0
`ifdef CASE_9_ACC_SAT_EN
        q_b.push_back({1'b1, 10'h1FF});
        q_b.push_back({1'b1, 10'h200});
        q_b.push_back({1'b0, 10'h000});
`else
        q_b.push_back({1'b0, 10'h3F8});
        q_b.push_back({1'b0, 10'h000});
        q_b.push_back({1'b0, 10'h000});
`endif
        for (int i = 0; i < 8; i++) send(1, 8'h7F);
        for (int i = 0; i < 8; i++) send(1, 8'h80);
        for (int i = 0; i < 8; i++) send(1, 8'h00);
        drain(1);

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
